// File: rtl/req_enc_pkg.sv
// Shared types and width helpers for the request-index encoders.
package req_enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_e;

    localparam int unsigned DefaultWidth = 8;

    // Index width for a request mask of the given width; never below 1 bit.
    function automatic int unsigned idx_w_of(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/lsb_index.sv
// Combinational find-first-set: index of the lowest set bit of req_i.
module lsb_index
    import req_enc_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    localparam int unsigned IDX_W = idx_w_of(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/req_index_encoder.sv
// Sequential priority encoder: serialises every set bit of a request mask
// as an index stream, lowest index first, over valid/ready handshakes.
module req_index_encoder
    import req_enc_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    localparam int unsigned IDX_W = idx_w_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_drop,
    output logic             busy
);

    enc_state_e       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             zero_drop_q, zero_drop_d;
    logic [IDX_W-1:0] ffs_idx;
    logic             pend_any;

    lsb_index #(
        .WIDTH (WIDTH)
    ) u_lsb_index (
        .req_i (pend_q),
        .idx_o (ffs_idx),
        .any_o (pend_any)
    );

    // Stream outputs depend on registers only; in_ready also sees out_ready so
    // a new mask can be taken during the final beat without a bubble.
    always_comb begin
        busy      = (state_q == EMIT);
        out_valid = busy & pend_any;
        out_idx   = busy ? ffs_idx : '0;
        out_last  = busy & ((pend_q & (pend_q - WIDTH'(1))) == '0);
        in_ready  = ~rst & (~busy | (out_ready & out_last));
        zero_drop = zero_drop_q;
    end

    // Next state: retire the emitted bit, then let an accepted mask override.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        zero_drop_d = 1'b0;
        if (out_valid && out_ready) begin
            pend_d = pend_q & ~(WIDTH'(1) << out_idx);
            if (out_last) begin
                state_d = IDLE;
            end
        end
        if (in_valid && in_ready) begin
            if (in_req != '0) begin
                pend_d  = in_req;
                state_d = EMIT;
            end else begin
                zero_drop_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            zero_drop_q <= zero_drop_d;
        end
    end

endmodule

// File: tb/tb_req_index_encoder.sv
// Self-checking bench for req_index_encoder: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_req_index_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_drop;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    req_index_encoder #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_drop (zero_drop),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]      mask;
        int              cnt;
        logic [7:0][2:0] seq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_vec(input vec_t v);
        in_valid  = 1'b1;
        in_req    = v.mask;
        out_ready = 1'b1;
        #1;
        chk("vec_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_req   = '0;
        for (int b = 0; b < v.cnt; b++) begin
            #1;
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_idx", int'(out_idx), int'(v.seq[b]));
            chk("vec_last", int'(out_last), (b == v.cnt - 1) ? 1 : 0);
            tick();
        end
        #1;
        chk("vec_done_valid", int'(out_valid), 0);
        chk("vec_done_busy", int'(busy), 0);
        tick();
    endtask

    int q[$];
    bit zd_exp;
    bit exp_ready;
    int hs;

    initial begin
        vecs[0].mask = 8'hA4; vecs[0].cnt = 3;
        vecs[0].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2};
        vecs[1].mask = 8'h01; vecs[1].cnt = 1;
        vecs[1].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[2].mask = 8'h80; vecs[2].cnt = 1;
        vecs[2].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
        vecs[3].mask = 8'h81; vecs[3].cnt = 2;
        vecs[3].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0};
        vecs[4].mask = 8'h18; vecs[4].cnt = 2;
        vecs[4].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3};
        vecs[5].mask = 8'h55; vecs[5].cnt = 4;
        vecs[5].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd2, 3'd0};
        vecs[6].mask = 8'hFF; vecs[6].cnt = 8;
        vecs[6].seq  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[7].mask = 8'h3C; vecs[7].cnt = 4;
        vecs[7].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2};

        // Reset held for 3 cycles.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_req    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_zero_drop", int'(zero_drop), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        tick();

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            send_vec(vecs[v]);
        end

        // 8'hFF with out_ready toggling 1,0,1,0,...
        in_valid = 1'b1;
        in_req   = 8'hFF;
        tick();
        in_valid = 1'b0;
        hs       = 0;
        for (int c = 0; c < 40 && hs < 8; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            chk("tog_valid", int'(out_valid), 1);
            chk("tog_idx", int'(out_idx), hs);
            chk("tog_last", int'(out_last), (hs == 7) ? 1 : 0);
            if (out_valid && out_ready) hs++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("tog_handshakes", hs, 8);
        chk("tog_done_valid", int'(out_valid), 0);
        tick();

        // Zero mask in IDLE.
        in_valid = 1'b1;
        in_req   = 8'h00;
        tick();
        in_valid = 1'b0;
        #1;
        chk("zero_pulse", int'(zero_drop), 1);
        chk("zero_valid", int'(out_valid), 0);
        tick();
        #1;
        chk("zero_pulse_end", int'(zero_drop), 0);
        chk("zero_valid_end", int'(out_valid), 0);
        tick();

        // Back-to-back: 8'h80 accepted during the last beat of 8'h01.
        in_valid = 1'b1;
        in_req   = 8'h01;
        tick();
        in_req = 8'h80;
        #1;
        chk("b2b_ready", int'(in_ready), 1);
        chk("b2b_idx0", int'(out_idx), 0);
        chk("b2b_last0", int'(out_last), 1);
        chk("b2b_busy0", int'(busy), 1);
        tick();
        in_valid = 1'b0;
        in_req   = '0;
        #1;
        chk("b2b_valid1", int'(out_valid), 1);
        chk("b2b_idx1", int'(out_idx), 7);
        chk("b2b_last1", int'(out_last), 1);
        chk("b2b_busy1", int'(busy), 1);
        tick();
        #1;
        chk("b2b_done_busy", int'(busy), 0);
        chk("b2b_done_valid", int'(out_valid), 0);
        tick();

        // Reset after 3 beats of 8'hFF.
        in_valid = 1'b1;
        in_req   = 8'hFF;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("mid_idx", int'(out_idx), b);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick();
        vecs[0].mask = 8'h10; vecs[0].cnt = 1;
        vecs[0].seq  = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4};
        send_vec(vecs[0]);

        // Randomized traffic against a queue of pending indices.
        q.delete();
        zd_exp = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(1, 0) == 1);
            in_req    = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom());
            out_ready = ($urandom_range(9, 0) < 7);
            #1;
            exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
            chk("rnd_in_ready", int'(in_ready), int'(exp_ready));
            chk("rnd_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
            chk("rnd_busy", int'(busy), (q.size() != 0) ? 1 : 0);
            chk("rnd_zero_drop", int'(zero_drop), int'(zd_exp));
            if (q.size() != 0) begin
                chk("rnd_idx", int'(out_idx), q[0]);
                chk("rnd_last", int'(out_last), (q.size() == 1) ? 1 : 0);
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            zd_exp = 1'b0;
            if (in_valid && exp_ready) begin
                if (in_req == 8'h00) begin
                    zd_exp = 1'b1;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (in_req[i]) q.push_back(i);
                    end
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
